// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: one activation per accept, OUTPUT_NODES parallel MAC lanes, bias/round/saturate.
// Latency: INPUT_NODES+2 cycles from start to out_valid, plus one cycle per ACCUM cycle with in_valid low.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready. FC_RELU_EN clamps negative lanes to 0.
module fc_layer_stream #(
   parameter int DATA_WIDTH   = 16,
   parameter int FRAC_BITS    = 8,
   parameter int INPUT_NODES  = 100,
   parameter int OUTPUT_NODES = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int ACC_WIDTH    = 40
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               in_valid,
   input  logic [DATA_WIDTH-1:0]              in_data,
   output logic                               in_ready,
   output logic [ADDR_WIDTH-1:0]              w_addr,
   input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] w_data,
   input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] bias,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_WIDTH*OUTPUT_NODES-1:0] out_fc,
   output logic                               busy
);

   // Two guard bits above the accumulator so that adding bias and the rounding
   // constant can never wrap before saturation.
   localparam int T_W = ACC_WIDTH + 2;
   localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(INPUT_NODES - 1);
   localparam logic signed [T_W-1:0] RND     = T_W'(1) << (FRAC_BITS - 1);
   localparam logic signed [T_W-1:0] SAT_MAX = {{(T_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [T_W-1:0] SAT_MIN = {{(T_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACCUM = 3'd1,
      S_DRAIN = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                            r_state;
   logic [ADDR_WIDTH-1:0]             r_w_addr;
   logic signed [DATA_WIDTH-1:0]      r_in_dat;
   logic                              r_mac_vld;
   logic                              r_in_ready;
   logic                              r_out_valid;
   logic                              r_busy;
   logic [DATA_WIDTH*OUTPUT_NODES-1:0] r_out_fc;
   logic signed [ACC_WIDTH-1:0]       r_acc [OUTPUT_NODES];

   logic                              w_accept;
   logic signed [2*DATA_WIDTH-1:0]    w_act_ext;
   logic signed [2*DATA_WIDTH-1:0]    w_wgt_ext [OUTPUT_NODES];
   logic signed [2*DATA_WIDTH-1:0]    w_prod    [OUTPUT_NODES];
   logic signed [T_W-1:0]             w_acc_ext [OUTPUT_NODES];
   logic signed [T_W-1:0]             w_bias_ext[OUTPUT_NODES];
   logic signed [T_W-1:0]             w_t       [OUTPUT_NODES];
   logic signed [T_W-1:0]             w_r       [OUTPUT_NODES];
   logic [DATA_WIDTH-1:0]             w_res     [OUTPUT_NODES];

   assign w_accept  = in_valid && r_in_ready;
   assign in_ready  = r_in_ready;
   assign w_addr    = r_w_addr;
   assign out_valid = r_out_valid;
   assign out_fc    = r_out_fc;
   assign busy      = r_busy;

   // Per-lane product of the registered activation with the weight row that
   // the memory returns one cycle after its address was presented.
   always_comb begin
      w_act_ext = {{DATA_WIDTH{r_in_dat[DATA_WIDTH-1]}}, r_in_dat};
      for (int j = 0; j < OUTPUT_NODES; j++) begin
         w_wgt_ext[j] = {{DATA_WIDTH{w_data[j*DATA_WIDTH+DATA_WIDTH-1]}},
                         w_data[j*DATA_WIDTH +: DATA_WIDTH]};
         w_prod[j]    = w_act_ext * w_wgt_ext[j];
      end
   end

   // Output stage: add bias aligned to the product scale, round half up,
   // drop the extra fraction, then saturate (and optionally rectify).
   always_comb begin
      for (int j = 0; j < OUTPUT_NODES; j++) begin
         w_acc_ext[j]  = {{(T_W-ACC_WIDTH){r_acc[j][ACC_WIDTH-1]}}, r_acc[j]};
         w_bias_ext[j] = {{(T_W-DATA_WIDTH){bias[j*DATA_WIDTH+DATA_WIDTH-1]}},
                          bias[j*DATA_WIDTH +: DATA_WIDTH]};
         w_t[j]        = w_acc_ext[j] + (w_bias_ext[j] <<< FRAC_BITS) + RND;
         w_r[j]        = w_t[j] >>> FRAC_BITS;
         if (w_r[j] > SAT_MAX) begin
            w_res[j] = SAT_MAX[DATA_WIDTH-1:0];
         end else if (w_r[j] < SAT_MIN) begin
            w_res[j] = SAT_MIN[DATA_WIDTH-1:0];
         end else begin
            w_res[j] = w_r[j][DATA_WIDTH-1:0];
         end
`ifdef FC_RELU_EN
         if (w_res[j][DATA_WIDTH-1]) begin
            w_res[j] = '0;
         end
`endif
      end
   end

   // Control FSM: sequences accepts, drain, result capture and output handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_w_addr    <= '0;
         r_in_dat    <= '0;
         r_mac_vld   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_fc    <= '0;
      end else begin
         r_mac_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_w_addr <= '0;
               if (start) begin
                  r_state    <= S_ACCUM;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_ACCUM: begin
               // w_addr doubles as the activation index k.
               if (w_accept) begin
                  r_in_dat  <= in_data;
                  r_mac_vld <= 1'b1;
                  r_w_addr  <= r_w_addr + 1'b1;
                  if (r_w_addr == LAST_K) begin
                     r_state    <= S_DRAIN;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               r_state <= S_FINAL;
            end
            S_FINAL: begin
               for (int j = 0; j < OUTPUT_NODES; j++) begin
                  r_out_fc[j*DATA_WIDTH +: DATA_WIDTH] <= w_res[j];
               end
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // Accumulators: cleared while idle, one MAC the cycle after each accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < OUTPUT_NODES; j++) begin
            r_acc[j] <= '0;
         end
      end else if (r_state == S_IDLE) begin
         for (int j = 0; j < OUTPUT_NODES; j++) begin
            r_acc[j] <= '0;
         end
      end else if (r_mac_vld) begin
         for (int j = 0; j < OUTPUT_NODES; j++) begin
            r_acc[j] <= r_acc[j] + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[j][2*DATA_WIDTH-1]}}, w_prod[j]};
         end
      end
   end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Bench for fc_layer_stream with DW=16, F=8, N=4, O=2: directed table, corner sequences, random vs reference model.
// Latency: checked against N+2 plus stall cycles for every inference.
// Backpressure: out_ready held low with start pulsed; output must stay frozen.
module tb_fc_layer_stream;

   localparam int DW = 16;
   localparam int N  = 4;
   localparam int O  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [DW-1:0]     in_data;
   logic              in_ready;
   logic [7:0]        w_addr;
   logic [DW*O-1:0]   w_data;
   logic [DW*O-1:0]   bias;
   logic              out_valid;
   logic              out_ready;
   logic [DW*O-1:0]   out_fc;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic [DW*O-1:0]   wrow [0:255];
   logic [DW-1:0]     cur_x [N];

   typedef struct {
      logic [63:0] x;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] b0;
      logic [15:0] b1;
      int          gap;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [6];

   fc_layer_stream #(
      .DATA_WIDTH(DW), .FRAC_BITS(8), .INPUT_NODES(N),
      .OUTPUT_NODES(O), .ADDR_WIDTH(8), .ACC_WIDTH(40)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .w_addr(w_addr), .w_data(w_data), .bias(bias),
      .out_valid(out_valid), .out_ready(out_ready), .out_fc(out_fc),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous weight memory, one-cycle read latency.
   always @(posedge clk) w_data <= wrow[w_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_w_addr", {24'd0, w_addr}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_fc", out_fc, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
   endtask

   // Reference: exact dot product, bias at product scale, +0.5 LSB, floor, clamp.
   function automatic logic [31:0] model();
      logic [31:0] res;
      longint s;
      res = '0;
      for (int j = 0; j < O; j++) begin
         s = 0;
         for (int k = 0; k < N; k++) begin
            s += longint'($signed(cur_x[k])) * longint'($signed(wrow[k][j*DW +: DW]));
         end
         s += longint'($signed(bias[j*DW +: DW])) * 256 + 128;
         s = s >>> 8;
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
         if (s < 0) s = 0;
`endif
         res[j*DW +: DW] = s[15:0];
      end
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One inference: start, N accepts with 'gap' idle cycles between them, wait for out_valid.
   task automatic run(input int gap, output int lat, output logic [31:0] res);
      int  cyc;
      bit  seen;
      start = 1'b1;
      in_valid = 1'b0;
      step();
      start = 1'b0;
      cyc = 0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b1;
         in_data  = cur_x[k];
         step();
         cyc++;
         in_valid = 1'b0;
         in_data  = DW'($urandom);
         if (k < N-1) begin
            for (int g = 0; g < gap; g++) begin
               step();
               cyc++;
               chk("w_addr_hold", {24'd0, w_addr}, k + 1);
            end
         end
      end
      seen = 1'b0;
      while (!seen && cyc < 60) begin
         step();
         cyc++;
         if (out_valid) seen = 1'b1;
      end
      if (!seen) chk("out_valid_timeout", 32'd0, 32'd1);
      lat = cyc;
      res = out_fc;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
      chk("hs_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic load_vec(input vec_t v);
      for (int k = 0; k < N; k++) begin
         cur_x[k] = v.x[k*16 +: 16];
         wrow[k]  = {v.w1, v.w0};
      end
      bias = {v.b1, v.b0};
   endtask

   task automatic small16(output logic [15:0] v);
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = {{6{v[9]}}, v[9:0]};
   endtask

   initial begin
      int          lat;
      logic [31:0] res;
      logic [31:0] hold;
      logic [15:0] tmp;
      int          gap;

      vt[0] = '{x:64'h0100_0100_0100_0100, w0:16'h0080, w1:16'h0080, b0:16'h0000, b1:16'h0000, gap:0, exp:32'h0200_0200};
      vt[1] = '{x:64'h0000_0000_0000_0001, w0:16'h0080, w1:16'hFF80, b0:16'h0000, b1:16'h0000, gap:0, exp:32'h0000_0001};
`ifdef FC_RELU_EN
      vt[2] = '{x:64'h0100_0100_0100_0100, w0:16'h0080, w1:16'hFF80, b0:16'h0100, b1:16'h0100, gap:0, exp:32'h0000_0300};
      vt[3] = '{x:64'h7FFF_7FFF_7FFF_7FFF, w0:16'h7FFF, w1:16'h8001, b0:16'h0000, b1:16'h0000, gap:0, exp:32'h0000_7FFF};
      vt[4] = '{x:64'hFF00_FF00_FF00_FF00, w0:16'h0100, w1:16'h0040, b0:16'h0000, b1:16'h0000, gap:1, exp:32'h0000_0000};
`else
      vt[2] = '{x:64'h0100_0100_0100_0100, w0:16'h0080, w1:16'hFF80, b0:16'h0100, b1:16'h0100, gap:0, exp:32'hFF00_0300};
      vt[3] = '{x:64'h7FFF_7FFF_7FFF_7FFF, w0:16'h7FFF, w1:16'h8001, b0:16'h0000, b1:16'h0000, gap:0, exp:32'h8000_7FFF};
      vt[4] = '{x:64'hFF00_FF00_FF00_FF00, w0:16'h0100, w1:16'h0040, b0:16'h0000, b1:16'h0000, gap:1, exp:32'hFF00_FC00};
`endif
      vt[5] = '{x:64'h0100_0100_0100_0100, w0:16'h0080, w1:16'h0080, b0:16'h0000, b1:16'h0000, gap:3, exp:32'h0200_0200};

      for (int a = 0; a < 256; a++) wrow[a] = '0;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; bias = '0;
      #12;
      chk_reset_vals();
      reset = 1'b0;
      step();

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         load_vec(vt[i]);
         run(vt[i].gap, lat, res);
         chk($sformatf("vec%0d_out", i), res, vt[i].exp);
         chk($sformatf("vec%0d_lat", i), lat, N + 2 + vt[i].gap * (N - 1));
         handshake();
      end

      // Output backpressure with start pulsed while DONE.
      load_vec(vt[0]);
      run(0, lat, res);
      hold = out_fc;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         step();
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_fc", out_fc, hold);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      start = 1'b0;
      handshake();
      step();
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);
      chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_fc_kept", out_fc, hold);

      // Reset after two accepts, then a clean nominal run.
      start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = cur_x[0];
      step();
      in_data = cur_x[1];
      step();
      in_valid = 1'b0;
      chk("mid_w_addr", {24'd0, w_addr}, 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals();
      step();
      reset = 1'b0;
      step();
      chk_reset_vals();
      run(0, lat, res);
      chk("post_rst_out", res, 32'h0200_0200);
      chk("post_rst_lat", lat, N + 2);
      handshake();

      // Randomized inferences against the reference model.
      for (int it = 0; it < 25; it++) begin
         for (int k = 0; k < N; k++) begin
            small16(tmp); cur_x[k] = tmp;
            small16(tmp); wrow[k][15:0]  = tmp;
            small16(tmp); wrow[k][31:16] = tmp;
         end
         small16(tmp); bias[15:0]  = tmp;
         small16(tmp); bias[31:16] = tmp;
         gap = $urandom_range(0, 2);
         run(gap, lat, res);
         chk("rnd_out", res, model());
         chk("rnd_lat", lat, N + 2 + gap * (N - 1));
         for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
            step();
            chk("rnd_hold", out_fc, res);
         end
         handshake();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
